rom_fetch_arbiter: RTL and testbench
====================================

# rom_fetch_arbiter

Shares one 16-bit, Wishbone-style read-only slave (the boot ROM) between two 32-bit read masters: instruction fetch on port 0 and debug/loader on port 1. Each granted 32-bit request becomes two sequential 16-bit slave reads, low halfword first. The block assembles the result and returns it with a single-cycle ack. Round-robin arbitration decides which master goes next when both are requesting.

## Interface
- AW, 8: byte-address width of the slave space; masters address 32-bit words, the slave addresses 16-bit halfwords.
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m0_adr_i  in  AW-2  word address, bits [AW-1:2].
- m0_stb_i  in  1  request; held high until m0_ack_o.
- m0_ack_o  out  1  one-cycle completion pulse.
- m0_dat_o  out  32  read data.
- m1_adr_i, m1_stb_i, m1_ack_o, m1_dat_o: same as port 0, for master 1.
- s_adr_o  out  AW-1  halfword address, bits [AW-1:1].
- s_stb_o  out  1  slave strobe.
- s_ack_i  in  1  slave ack; may be combinational (same cycle) or delayed by any number of cycles.
- s_dat_i  in  16  slave read data; valid while s_ack_i is high.

## Operation
- FSM states: IDLE, LO, HI, ACK.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one stb high: register that master as `gnt` and go to LO.
  - Both high: grant the master that is not `last`.
- **LO**
  - s_adr_o = {adr of gnt, 1'b0}; s_stb_o = stb of gnt.
  - On s_ack_i: lo_reg <= s_dat_i, go to HI.
- **HI**
  - s_adr_o = {adr of gnt, 1'b1}; s_stb_o = stb of gnt.
  - On s_ack_i: hi_reg <= s_dat_i, go to ACK.
- **ACK**
  - Granted master's ack_o = 1 for exactly one cycle.
  - `last` <= gnt; go to IDLE.
- Data output: m0_dat_o and m1_dat_o both equal {hi_reg, lo_reg}. Only the acked master may sample it, and only in its ack cycle.
- Address capture: the master address is not registered. The master must hold adr_i stable while stb_i is high.
- Abort: if the granted master drops stb_i in LO or HI:
  - s_stb_o falls combinationally in that same cycle;
  - the next edge returns the FSM to IDLE;
  - no ack is issued; lo_reg/hi_reg may hold partial data; `last` is unchanged.
- Non-granted master: stb_i is ignored until the FSM is back in IDLE; its ack_o stays 0.
- Slave ack outside LO/HI: ignored.
- s_adr_o in IDLE and ACK: 0.

## Timing
- Reset values (asynchronous assert on rst_i high):
  - state = IDLE, gnt = 0, `last` = 1 (so m0 wins the first tie);
  - lo_reg = hi_reg = 0;
  - all acks = 0, s_stb_o = 0, s_adr_o = 0.
- Reset mid-transaction: immediate return to reset values; no ack for the pending request.
- Reset release: the first grant is possible on the first rising edge after rst_i falls.
- Latency with a zero-wait slave: stb_i seen in IDLE at edge N gives LO in cycle N+1, HI in N+2, ack in N+3.
- Each slave wait cycle adds one cycle to the ack latency.
- Back-to-back: the master drops stb_i on the edge that samples its ack. A new request can be granted on the edge after ACK (IDLE cycle), so zero-wait throughput is 4 cycles per word.
- Fairness: with both masters requesting continuously, grants strictly alternate. No master waits more than one full transaction.
- s_stb_o is never high in IDLE or ACK.
- s_stb_o is high for at least one cycle per halfword.
- Strobe state is not carried between halfwords: HI always starts a fresh strobe cycle, even when LO ended on a combinational ack.

## Test plan
- Reset: hold rst_i high, toggle the clock. Expect all acks 0, s_stb_o 0, m0_dat_o = 0x00000000, no ack after release while both stb are low.
- Single fetch, boot ROM image as slave: m0 adr = 0. Expect s_adr_o 0 then 1, m0_ack_o 3 cycles after the request, m0_dat_o = 0x00000113. Then m1 adr = 5 gives m1_dat_o = 0xFF5FF06F.
- Contention: m0 and m1 both request continuously from reset, adr 1 and 2. Expect acks in order m0, m1, m0, m1, with data 0x001001B7 / 0x00110113, 4 cycles apart.
- Wait states: slave acks 2 cycles after each strobe rises, m0 adr = 2. Expect ack at cycle N+7 with data 0x00110113 and s_adr_o held stable during each wait.
- Abort: m1 drops stb in LO.
  - Expect s_stb_o low that cycle, IDLE next cycle, m1_ack_o never asserted.
  - A following tie with m0 is granted to m0, because `last` is unchanged at its reset value.
- Reset mid-HI: assert rst_i during HI. Expect no ack, lo_reg = 0. The next m0 fetch of adr 0 still returns 0x00000113.

Source files
------------

// File: rtl/rom_fetch_arbiter_if.sv
// Bundles the two 32-bit read-master ports and the 16-bit boot-ROM slave
// port of rom_fetch_arbiter. Signal suffixes are from the arbiter's view:
// _i is driven into the arbiter, _o is driven by it.
//
//   m0_adr_i / m1_adr_i  word address, byte-address bits [AW-1:2]
//   m0_stb_i / m1_stb_i  request, held until the matching ack
//   m0_ack_o / m1_ack_o  one-cycle completion pulse
//   m0_dat_o / m1_dat_o  assembled 32-bit read data
//   s_adr_o              halfword address, byte-address bits [AW-1:1]
//   s_stb_o              slave strobe
//   s_ack_i              slave ack (combinational or delayed)
//   s_dat_i              slave read data, valid with s_ack_i
//
// Modport slave is the arbiter side; modport master is the environment
// (the two requesters plus the ROM) that surrounds it.
interface rom_fetch_arbiter_if #(
    parameter int unsigned AW = 8
) ();
    localparam int unsigned WORD_AW = AW - 2;
    localparam int unsigned HALF_AW = AW - 1;
    localparam int unsigned WORD_DW = 32;
    localparam int unsigned HALF_DW = 16;

    logic [WORD_AW-1:0] m0_adr_i;
    logic               m0_stb_i;
    logic               m0_ack_o;
    logic [WORD_DW-1:0] m0_dat_o;

    logic [WORD_AW-1:0] m1_adr_i;
    logic               m1_stb_i;
    logic               m1_ack_o;
    logic [WORD_DW-1:0] m1_dat_o;

    logic [HALF_AW-1:0] s_adr_o;
    logic               s_stb_o;
    logic               s_ack_i;
    logic [HALF_DW-1:0] s_dat_i;

    modport slave (
        input  m0_adr_i, m0_stb_i,
        output m0_ack_o, m0_dat_o,
        input  m1_adr_i, m1_stb_i,
        output m1_ack_o, m1_dat_o,
        output s_adr_o,  s_stb_o,
        input  s_ack_i,  s_dat_i
    );

    modport master (
        output m0_adr_i, m0_stb_i,
        input  m0_ack_o, m0_dat_o,
        output m1_adr_i, m1_stb_i,
        input  m1_ack_o, m1_dat_o,
        input  s_adr_o,  s_stb_o,
        output s_ack_i,  s_dat_i
    );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares one 16-bit read-only slave (the boot ROM) between
// two 32-bit read masters, instruction fetch on port 0 and debug/loader on
// port 1. A granted word request is split into two slave reads, low halfword
// first, and completed with a one-cycle ack. Ties go round-robin.
//
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  asynchronous active-high reset
//   bus    rom_fetch_arbiter_if.slave (master ports 0/1 and the ROM port)
//
// The master address is not captured: s_adr_o and s_stb_o follow the granted
// master's adr/stb combinationally so that dropping stb aborts the slave
// cycle in the same clock. The acks and read data are registered.
module rom_fetch_arbiter #(
    parameter int unsigned AW = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rom_fetch_arbiter_if.slave  bus
);
    localparam int unsigned WORD_AW = AW - 2;
    localparam int unsigned HALF_AW = AW - 1;
    localparam int unsigned HALF_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        ACK  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 gnt_q,   gnt_d;     // 0: master 0, 1: master 1
    logic                 last_q,  last_d;    // master served most recently
    logic [HALF_DW-1:0]   lo_q,    lo_d;
    logic [HALF_DW-1:0]   hi_q,    hi_d;
    logic                 ack0_q,  ack0_d;
    logic                 ack1_q,  ack1_d;

    logic                 gnt_stb;
    logic [WORD_AW-1:0]   gnt_adr;
    logic                 s_stb;
    logic [HALF_AW-1:0]   s_adr;

    // Request/address of whichever master currently holds the grant.
    always_comb begin
        gnt_stb = gnt_q ? bus.m1_stb_i : bus.m0_stb_i;
        gnt_adr = gnt_q ? bus.m1_adr_i : bus.m0_adr_i;
    end

    // State register; reset leaves last = 1 so master 0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            lo_q    <= '0;
            hi_q    <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    // Next-state, data capture and slave-port drive.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        s_stb   = 1'b0;
        s_adr   = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.m0_stb_i && bus.m1_stb_i) begin
                    gnt_d   = ~last_q;
                    state_d = LO;
                end else if (bus.m0_stb_i) begin
                    gnt_d   = 1'b0;
                    state_d = LO;
                end else if (bus.m1_stb_i) begin
                    gnt_d   = 1'b1;
                    state_d = LO;
                end
            end

            LO: begin
                s_adr = {gnt_adr, 1'b0};
                s_stb = gnt_stb;
                // Abort wins over a coincident slave ack.
                if (!gnt_stb) begin
                    state_d = IDLE;
                end else if (bus.s_ack_i) begin
                    lo_d    = bus.s_dat_i;
                    state_d = HI;
                end
            end

            HI: begin
                s_adr = {gnt_adr, 1'b1};
                s_stb = gnt_stb;
                if (!gnt_stb) begin
                    state_d = IDLE;
                end else if (bus.s_ack_i) begin
                    hi_d    = bus.s_dat_i;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = ACK;
                end
            end

            ACK: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.s_stb_o  = s_stb;
    assign bus.s_adr_o  = s_adr;
    assign bus.m0_ack_o = ack0_q;
    assign bus.m1_ack_o = ack1_q;
    assign bus.m0_dat_o = {hi_q, lo_q};
    assign bus.m1_dat_o = {hi_q, lo_q};

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Bench for rom_fetch_arbiter: a ROM slave model with programmable wait
// states, two master drivers and a scoreboard monitor that checks every ack.
module tb_rom_fetch_arbiter;
    localparam int unsigned AW  = 8;
    localparam int unsigned NHW = 1 << (AW - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_fetch_arbiter_if #(.AW(AW)) bus ();

    rom_fetch_arbiter #(.AW(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] rom16 [NHW];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          ack_who[$];
    int          ack_cyc[$];
    int          acc_log[$];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: a word is two consecutive halfwords, low one at the even address.
    function automatic logic [31:0] rom_word(input int a);
        return {rom16[2*a+1], rom16[2*a]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ROM slave: acks cur_wait cycles after each access starts; an access
    // restarts after every ack even if the strobe stays high.
    int   fixed_wait = 0;
    int   rnd_wait   = 0;
    bit   rand_wait  = 1'b0;
    bit   spur_en    = 1'b0;
    logic spur       = 1'b0;
    int   scnt       = 0;
    int   cur_wait;

    assign cur_wait     = rand_wait ? rnd_wait : fixed_wait;
    assign bus.s_ack_i  = bus.s_stb_o ? (scnt == cur_wait) : spur;
    assign bus.s_dat_i  = rom16[bus.s_adr_o];

    always @(posedge clk) begin
        if (!bus.s_stb_o || bus.s_ack_i) scnt <= 0;
        else                             scnt <= scnt + 1;
        if (bus.s_stb_o && bus.s_ack_i)  rnd_wait <= int'($urandom_range(0, 3));
        spur <= spur_en && ($urandom_range(0, 3) == 0);
    end

    // Scoreboard monitor.
    int          wait0 = 0;
    int          wait1 = 0;
    logic        prev_stb = 1'b0;
    logic        prev_ack = 1'b0;
    logic [6:0]  prev_adr = '0;
    logic [31:0] e;

    always @(negedge clk) begin
        if (rst) begin
            wait0    <= 0;
            wait1    <= 0;
            prev_stb <= 1'b0;
            prev_ack <= 1'b0;
        end else begin
            if (bus.m0_ack_o || bus.m1_ack_o) begin
                chk("ack_exclusive", 32'(bus.m0_ack_o & bus.m1_ack_o), 32'd0);
                chk("ack_cycle_s_stb", 32'(bus.s_stb_o), 32'd0);
                chk("ack_cycle_s_adr", 32'(bus.s_adr_o), 32'd0);
            end
            if (bus.m0_ack_o) begin
                if (exp_q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m0_unexpected_ack: got ack, expected none (t=%0t)", $time);
                end else begin
                    e = exp_q0.pop_front();
                    chk("m0_data", bus.m0_dat_o, e);
                end
                ack_who.push_back(0);
                ack_cyc.push_back(cyc);
            end
            if (bus.m1_ack_o) begin
                if (exp_q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m1_unexpected_ack: got ack, expected none (t=%0t)", $time);
                end else begin
                    e = exp_q1.pop_front();
                    chk("m1_data", bus.m1_dat_o, e);
                end
                ack_who.push_back(1);
                ack_cyc.push_back(cyc);
            end
            // A waiting master may see the other served at most once.
            if (!bus.m0_stb_i || bus.m0_ack_o) wait0 <= 0;
            else if (bus.m1_ack_o) begin
                chk("fairness_m0_passed_over", 32'(wait0 >= 1), 32'd0);
                wait0 <= wait0 + 1;
            end
            if (!bus.m1_stb_i || bus.m1_ack_o) wait1 <= 0;
            else if (bus.m0_ack_o) begin
                chk("fairness_m1_passed_over", 32'(wait1 >= 1), 32'd0);
                wait1 <= wait1 + 1;
            end
            if (bus.s_stb_o && prev_stb && !prev_ack)
                chk("s_adr_stable_in_wait", 32'(bus.s_adr_o), 32'(prev_adr));
            if (bus.s_stb_o && bus.s_ack_i) acc_log.push_back(int'(bus.s_adr_o));
            prev_stb <= bus.s_stb_o;
            prev_ack <= bus.s_stb_o && bus.s_ack_i;
            prev_adr <= bus.s_adr_o;
        end
    end

    // One word read by master k; call just after a rising edge, returns likewise.
    task automatic fetch(input int k, input int adr, input int exp_lat);
        int n;
        bit got;
        if (k == 0) begin
            exp_q0.push_back(rom_word(adr));
            bus.m0_adr_i = 6'(adr);
            bus.m0_stb_i = 1'b1;
        end else begin
            exp_q1.push_back(rom_word(adr));
            bus.m1_adr_i = 6'(adr);
            bus.m1_stb_i = 1'b1;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = (k == 0) ? bus.m0_ack_o : bus.m1_ack_o;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL fetch_timeout m%0d adr %0d: no ack after %0d cycles, expected ack", k, adr, n);
            if (k == 0 && exp_q0.size() > 0) void'(exp_q0.pop_back());
            if (k == 1 && exp_q1.size() > 0) void'(exp_q1.pop_back());
        end else if (exp_lat >= 0) begin
            chk($sformatf("latency_m%0d_adr%0d", k, adr), 32'(n - 1), 32'(exp_lat));
        end
        @(posedge clk);
        #1;
        if (k == 0) bus.m0_stb_i = 1'b0;
        else        bus.m1_stb_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(NHW); i++) rom16[i] = 16'($urandom);
        rom16[0]  = 16'h0113; rom16[1]  = 16'h0000;
        rom16[2]  = 16'h01B7; rom16[3]  = 16'h0010;
        rom16[4]  = 16'h0113; rom16[5]  = 16'h0011;
        rom16[10] = 16'hF06F; rom16[11] = 16'hFF5F;
        rom16[6]  = rom16[6] | 16'h0001;
        bus.m0_adr_i = '0; bus.m0_stb_i = 1'b0;
        bus.m1_adr_i = '0; bus.m1_stb_i = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_ack", 32'(bus.m0_ack_o), 32'd0);
        chk("rst_m1_ack", 32'(bus.m1_ack_o), 32'd0);
        chk("rst_s_stb", 32'(bus.s_stb_o), 32'd0);
        chk("rst_s_adr", 32'(bus.s_adr_o), 32'd0);
        chk("rst_m0_dat", bus.m0_dat_o, 32'h0000_0000);
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_ack", 32'(bus.m0_ack_o | bus.m1_ack_o), 32'd0);

        // Single fetches with a zero-wait slave.
        @(posedge clk); #1;
        acc_log.delete();
        fetch(0, 0, 3);
        chk("m0_word0_value", rom_word(0), 32'h0000_0113);
        chk("single_m0_acc_count", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() == 2) begin
            chk("single_m0_lo_adr", 32'(acc_log[0]), 32'd0);
            chk("single_m0_hi_adr", 32'(acc_log[1]), 32'd1);
        end
        acc_log.delete();
        fetch(1, 5, 3);
        chk("single_m1_acc_count", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() == 2) begin
            chk("single_m1_lo_adr", 32'(acc_log[0]), 32'd10);
            chk("single_m1_hi_adr", 32'(acc_log[1]), 32'd11);
        end

        // Contention from reset: strict alternation, 4 cycles apart.
        do_reset();
        ack_who.delete();
        ack_cyc.delete();
        fork
            begin fetch(0, 1, 3); fetch(0, 1, 7); end
            begin fetch(1, 2, 7); fetch(1, 2, 7); end
        join
        chk("contend_ack_count", 32'(ack_who.size()), 32'd4);
        if (ack_who.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("contend_order_%0d", i), 32'(ack_who[i]), 32'(i % 2));
                if (i > 0) chk($sformatf("contend_gap_%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
            end
        end

        // Wait states: two cycles per halfword.
        fixed_wait = 2;
        fetch(0, 2, 7);

        // Abort: m1 drops stb in LO; the following tie still favours m0.
        do_reset();
        fixed_wait = 3;
        bus.m1_adr_i = 6'd3;
        bus.m1_stb_i = 1'b1;
        @(posedge clk); #1;
        bus.m1_stb_i = 1'b0;
        @(negedge clk);
        chk("abort_s_stb_low", 32'(bus.s_stb_o), 32'd0);
        fixed_wait = 0;
        @(posedge clk); #1;
        ack_who.delete();
        fork
            fetch(0, 4, 3);
            fetch(1, 6, 7);
        join

        // Reset during HI: no ack, partial data cleared, next fetch clean.
        fixed_wait = 3;
        bus.m0_adr_i = 6'd3;
        bus.m0_stb_i = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("midhi_lo_captured", 32'(bus.m0_dat_o[15:0]), 32'(rom16[6]));
        @(posedge clk); #1;
        rst = 1'b1;
        bus.m0_stb_i = 1'b0;
        @(negedge clk);
        chk("midhi_rst_ack", 32'(bus.m0_ack_o), 32'd0);
        chk("midhi_rst_s_stb", 32'(bus.s_stb_o), 32'd0);
        chk("midhi_rst_dat", bus.m0_dat_o, 32'h0000_0000);
        @(posedge clk); #1;
        rst = 1'b0;
        fixed_wait = 0;
        fetch(0, 0, 3);

        // Randomised traffic with random wait states and stray slave acks.
        rand_wait = 1'b1;
        spur_en   = 1'b1;
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                fetch(0, int'($urandom_range(0, 63)), -1);
            end
            for (int j = 0; j < 40; j++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                fetch(1, int'($urandom_range(0, 63)), -1);
            end
        join
        rand_wait = 1'b0;
        spur_en   = 1'b0;

        repeat (5) @(negedge clk);
        chk("drain_m0_queue", 32'(exp_q0.size()), 32'd0);
        chk("drain_m1_queue", 32'(exp_q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
